// File: rtl/reset_sequencer.sv
// Power-on / PLL-lock reset sequencer: holds, stretches, then releases NUM_OUT resets in a staggered order.
// Optional watchdog compiled in with `define RESET_SEQ_WATCHDOG_EN.
module reset_sequencer #(
    parameter int unsigned NUM_OUT        = 3,
    parameter int unsigned STRETCH_CYCLES = 32,
    parameter int unsigned STAGGER        = 4,
    parameter int unsigned WDOG_CYCLES    = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               sw_rst_req,
    input  logic               wdog_kick,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               ready,
    output logic               wdog_fired,
    output logic [1:0]         state
);

    localparam int unsigned SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int unsigned TW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int unsigned IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t cur, nxt;

    logic [1:0]         rst_sync;
    logic [1:0]         lock_sync;
    logic               rst_ok;
    logic               lock_s;
    logic [SW-1:0]      stretch_cnt, stretch_nxt;
    logic [TW-1:0]      stag_cnt, stag_nxt;
    logic [IW-1:0]      idx, idx_nxt;
    logic [NUM_OUT-1:0] out_nxt;
    logic               ready_nxt;
    logic               force_hold;
    logic               wdog_expire;

    // Reset release is synchronized so the FSM never leaves HOLD on a metastable deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync  <= '0;
            lock_sync <= '0;
        end else begin
            rst_sync  <= {rst_sync[0], 1'b1};
            lock_sync <= {lock_sync[0], pll_locked};
        end
    end

    assign rst_ok = rst_sync[1];
    assign lock_s = lock_sync[1];

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYCLES);

    logic [WW-1:0] wdog_cnt, wdog_cnt_nxt;
    logic          fired_q;

    always_comb begin
        wdog_cnt_nxt = '0;
        wdog_expire  = 1'b0;
        if (cur == RUN && !wdog_kick) begin
            if (wdog_cnt == WW'(WDOG_CYCLES - 1))
                wdog_expire = 1'b1;
            else
                wdog_cnt_nxt = wdog_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            fired_q  <= 1'b0;
        end else begin
            wdog_cnt <= (nxt == RUN) ? wdog_cnt_nxt : '0;
            if (wdog_expire)
                fired_q <= 1'b1;
        end
    end

    assign wdog_fired = fired_q;
`else
    logic unused_wdog;

    assign unused_wdog = wdog_kick | (WDOG_CYCLES == 0);
    assign wdog_expire = 1'b0;
    assign wdog_fired  = 1'b0;
`endif

    assign force_hold = !lock_s || (sw_rst_req && cur != HOLD) || wdog_expire;

    always_comb begin
        nxt         = cur;
        out_nxt     = rst_out;
        ready_nxt   = ready;
        stretch_nxt = stretch_cnt;
        stag_nxt    = stag_cnt;
        idx_nxt     = idx;
        case (cur)
            HOLD: begin
                out_nxt     = '1;
                ready_nxt   = 1'b0;
                stretch_nxt = '0;
                stag_nxt    = '0;
                idx_nxt     = '0;
                if (lock_s && rst_ok)
                    nxt = STRETCH;
            end
            STRETCH: begin
                if (stretch_cnt == SW'(STRETCH_CYCLES - 1)) begin
                    stretch_nxt = '0;
                    out_nxt[0]  = 1'b0;
                    stag_nxt    = '0;
                    // A single channel has nothing to stagger, so RUN is entered on bit 0's release.
                    if (NUM_OUT == 1) begin
                        nxt       = RUN;
                        ready_nxt = 1'b1;
                    end else begin
                        nxt     = RELEASE;
                        idx_nxt = IW'(1);
                    end
                end else begin
                    stretch_nxt = stretch_cnt + SW'(1);
                end
            end
            RELEASE: begin
                if (stag_cnt == TW'(STAGGER - 1)) begin
                    stag_nxt     = '0;
                    out_nxt[idx] = 1'b0;
                    if (idx == IW'(NUM_OUT - 1)) begin
                        nxt       = RUN;
                        ready_nxt = 1'b1;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end else begin
                    stag_nxt = stag_cnt + TW'(1);
                end
            end
            RUN: begin
                out_nxt   = '0;
                ready_nxt = 1'b1;
            end
            default: nxt = HOLD;
        endcase
        if (force_hold) begin
            nxt         = HOLD;
            out_nxt     = '1;
            ready_nxt   = 1'b0;
            stretch_nxt = '0;
            stag_nxt    = '0;
            idx_nxt     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= HOLD;
            rst_out     <= '1;
            ready       <= 1'b0;
            stretch_cnt <= '0;
            stag_cnt    <= '0;
            idx         <= '0;
        end else begin
            cur         <= nxt;
            rst_out     <= out_nxt;
            ready       <= ready_nxt;
            stretch_cnt <= stretch_nxt;
            stag_cnt    <= stag_nxt;
            idx         <= idx_nxt;
        end
    end

    assign state = cur;

endmodule
